// File: rtl/const_lut_pkg.sv
// Shared types, default constant table and default-value helper for const_lut.
package const_lut_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } lut_state_t;

  localparam int unsigned NUM_DEFAULTS = 8;
  localparam int unsigned MAX_DATA_W   = 64;

  // Power-on constants for entries 0..7: 100, 10, 5, 2, 1, 0, -1, -30.
  localparam logic [7:0] DEFAULT_VALS [NUM_DEFAULTS] = '{
    8'd100, 8'd10, 8'd5, 8'd2, 8'd1, 8'd0, 8'hFF, 8'hE2
  };

  // Default for entry idx, sign-extended and masked to data_w bits; entries
  // beyond the constant list default to zero. Callers truncate to their width.
  function automatic logic [MAX_DATA_W-1:0] default_value(input int unsigned idx,
                                                          input int unsigned data_w);
    logic [MAX_DATA_W-1:0] v;
    v = '0;
    if (idx < NUM_DEFAULTS) begin
      v = {{(MAX_DATA_W-8){DEFAULT_VALS[idx[2:0]][7]}}, DEFAULT_VALS[idx[2:0]]};
    end
    if (data_w < MAX_DATA_W) begin
      v &= ~({MAX_DATA_W{1'b1}} << data_w);
    end
    return v;
  endfunction

endpackage

// File: rtl/const_lut_if.sv
// Read/write/control bundle between instruction decode and the constant table.
interface const_lut_if #(
  parameter int IDX_W  = 3,
  parameter int DATA_W = 8
);

  logic              restore;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              ready;

  // Requester side (decode / test driver).
  modport master (
    output restore, rd_en, rd_idx, wr_en, wr_idx, wr_data,
    input  rd_data, rd_valid, rd_err, ready
  );

  // Table side.
  modport slave (
    input  restore, rd_en, rd_idx, wr_en, wr_idx, wr_data,
    output rd_data, rd_valid, rd_err, ready
  );

endinterface

// File: rtl/const_lut_init_seq.sv
// Reload sequencer: walks every entry writing its default after reset or a
// restore request, then hands the single table write port to the user.
module const_lut_init_seq
  import const_lut_pkg::*;
#(
  parameter int IDX_W  = 3,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_restore,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_ready,
  output logic              o_mem_we,
  output logic [IDX_W-1:0]  o_mem_idx,
  output logic [DATA_W-1:0] o_mem_data
);

  localparam logic [0:0]       ST_INIT  = INIT;
  localparam logic [0:0]       ST_READY = READY;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  logic [0:0]        r_state;
  logic [IDX_W-1:0]  r_init_idx;
  logic [DATA_W-1:0] w_def;

  assign w_def = DATA_W'(default_value(32'(r_init_idx), DATA_W));

  // Sequencer state: step through the table in INIT, wait for restore in READY.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_INIT;
      r_init_idx <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_idx == LAST_IDX) begin
            r_state    <= ST_READY;
            r_init_idx <= '0;
          end else begin
            r_init_idx <= r_init_idx + IDX_W'(1);
          end
        end
        ST_READY: begin
          if (i_restore) r_state <= ST_INIT;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // Write-port mux: the sequencer owns the port during INIT, the user otherwise.
  // NOTE: every output gets a default first so no path through this block
  // leaves a value unassigned and infers a latch.
  always_comb begin
    o_ready    = 1'b0;
    o_mem_we   = 1'b0;
    o_mem_idx  = i_wr_idx;
    o_mem_data = i_wr_data;
    if (r_state == ST_INIT) begin
      o_mem_we   = !i_reset;
      o_mem_idx  = r_init_idx;
      o_mem_data = w_def;
    end else begin
      o_ready    = 1'b1;
      o_mem_we   = i_wr_en && !i_reset;
    end
  end

endmodule

// File: rtl/const_lut.sv
// Writable constant table: storage, registered read with write-first bypass,
// and dropped-read error flag. Sits between decode and the ALU operand mux.
module const_lut
  import const_lut_pkg::*;
#(
  parameter int IDX_W  = 3,
  parameter int DATA_W = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  const_lut_if.slave  bus
);

  localparam int DEPTH = 2**IDX_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_rd_err;

  logic              w_ready;
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_mem_idx;
  logic [DATA_W-1:0] w_mem_data;
  logic              w_rd_accept;
  logic [DATA_W-1:0] w_rd_word;

  const_lut_init_seq #(
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_init_seq (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_restore  (bus.restore),
    .i_wr_en    (bus.wr_en),
    .i_wr_idx   (bus.wr_idx),
    .i_wr_data  (bus.wr_data),
    .o_ready    (w_ready),
    .o_mem_we   (w_mem_we),
    .o_mem_idx  (w_mem_idx),
    .o_mem_data (w_mem_data)
  );

  assign w_rd_accept = bus.rd_en && w_ready;

  // Write-first: a read colliding with this cycle's write returns the new data.
  assign w_rd_word = (w_mem_we && (w_mem_idx == bus.rd_idx)) ? w_mem_data
                                                              : r_mem[bus.rd_idx];

  // Table storage, written by the sequencer or the user through one port.
  // NOTE: the array has no reset; the INIT sweep rewrites every entry, so
  // clearing it would only cost a reset tree on every storage bit.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_mem_data;
  end

  // Read pipeline: capture accepted reads, flag reads dropped while not ready.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_accept;
      r_rd_err   <= bus.rd_en && !w_ready;
      if (w_rd_accept) r_rd_data <= w_rd_word;
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_err   = r_rd_err;
  assign bus.ready    = w_ready;

endmodule

// File: tb/tb_const_lut.sv
// Self-checking bench for const_lut: directed scenarios plus randomized traffic
// on an 8x8 instance against a table-level model, and a 16x16 instance check.
module tb_const_lut;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  const_lut_if #(.IDX_W(3), .DATA_W(8))  bus_a ();
  const_lut_if #(.IDX_W(4), .DATA_W(16)) bus_b ();

  const_lut #(.IDX_W(3), .DATA_W(8)) u_dut_a (
    .i_clk   (clk),
    .i_reset (rst_a),
    .bus     (bus_a)
  );

  const_lut #(.IDX_W(4), .DATA_W(16)) u_dut_b (
    .i_clk   (clk),
    .i_reset (rst_b),
    .bus     (bus_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of the 8-entry table, described at the level of
  // "table contents + time left until initialised".
  int         def_vals [8] = '{100, 10, 5, 2, 1, 0, -1, -30};
  logic [7:0] exp8     [8] = '{8'h64, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00, 8'hFF, 8'hE2};
  logic [7:0] m_mem    [8];
  bit         m_ready    = 1'b0;
  int         m_left     = 8;
  logic [7:0] m_rd_data  = '0;
  bit         m_rd_valid = 1'b0;
  bit         m_rd_err   = 1'b0;

  task automatic model_step();
    if (rst_a) begin
      m_ready    = 1'b0;
      m_left     = 8;
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_rd_err   = 1'b0;
    end else if (m_ready) begin
      m_rd_err   = 1'b0;
      m_rd_valid = bus_a.rd_en;
      if (bus_a.rd_en) begin
        if (bus_a.wr_en && bus_a.wr_idx == bus_a.rd_idx) m_rd_data = bus_a.wr_data;
        else                                             m_rd_data = m_mem[bus_a.rd_idx];
      end
      if (bus_a.wr_en) m_mem[bus_a.wr_idx] = bus_a.wr_data;
      if (bus_a.restore) begin
        m_ready = 1'b0;
        m_left  = 8;
      end
    end else begin
      m_rd_valid = 1'b0;
      m_rd_err   = bus_a.rd_en;
      m_left--;
      if (m_left == 0) begin
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) m_mem[i] = 8'(def_vals[i]);
      end
    end
  endtask

  task automatic drive_a(input bit restore, input bit rd_en, input int rd_idx,
                         input bit wr_en, input int wr_idx, input int wr_data);
    bus_a.restore = restore;
    bus_a.rd_en   = rd_en;
    bus_a.rd_idx  = 3'(rd_idx);
    bus_a.wr_en   = wr_en;
    bus_a.wr_idx  = 3'(wr_idx);
    bus_a.wr_data = 8'(wr_data);
  endtask

  // One clock: advance the model on the edge, compare all outputs 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("ready",    32'(bus_a.ready),    32'(m_ready));
    check("rd_valid", 32'(bus_a.rd_valid), 32'(m_rd_valid));
    check("rd_err",   32'(bus_a.rd_err),   32'(m_rd_err));
    check("rd_data",  32'(bus_a.rd_data),  32'(m_rd_data));
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive_a(0, 0, 0, 0, 0, 0);
    bus_b.restore = 1'b0;
    bus_b.rd_en   = 1'b0;
    bus_b.rd_idx  = '0;
    bus_b.wr_en   = 1'b0;
    bus_b.wr_idx  = '0;
    bus_b.wr_data = '0;

    cycle();
    cycle();
    rst_a = 1'b0;

    // Power-up INIT: a dropped read at edge 3, an ignored write at edge 4.
    for (int k = 1; k <= 8; k++) begin
      if (k == 3)      drive_a(0, 1, 1, 0, 0, 0);
      else if (k == 4) drive_a(0, 0, 0, 1, 5, 8'h77);
      else             drive_a(0, 0, 0, 0, 0, 0);
      cycle();
      check("init_ready", 32'(bus_a.ready), 32'(k == 8));
      if (k == 3) check("init_rd_err", 32'(bus_a.rd_err), 32'd1);
    end

    // Every default, one read per cycle.
    for (int i = 0; i < 8; i++) begin
      drive_a(0, 1, i, 0, 0, 0);
      cycle();
      check("default", 32'(bus_a.rd_data), 32'(exp8[i]));
      check("dflt_valid", 32'(bus_a.rd_valid), 32'd1);
    end
    drive_a(0, 0, 0, 0, 0, 0);
    cycle();

    // Plain write then read; then same-cycle write/read collision.
    drive_a(0, 0, 0, 1, 3, 8'h5A);
    cycle();
    drive_a(0, 1, 3, 0, 0, 0);
    cycle();
    check("wr_rd", 32'(bus_a.rd_data), 32'h5A);
    drive_a(0, 1, 2, 1, 2, 8'h33);
    cycle();
    check("bypass", 32'(bus_a.rd_data), 32'h33);
    drive_a(0, 0, 0, 0, 0, 0);
    cycle();

    // Overwrite idx0, restore, wait out INIT, default must be back.
    drive_a(0, 0, 0, 1, 0, 8'h11);
    cycle();
    drive_a(1, 0, 0, 0, 0, 0);
    cycle();
    drive_a(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      cycle();
      check("restore_ready", 32'(bus_a.ready), 32'(k == 8));
    end
    drive_a(0, 1, 0, 0, 0, 0);
    cycle();
    check("restored", 32'(bus_a.rd_data), 32'h64);

    // Reset in the middle of INIT restarts the full sweep.
    drive_a(1, 0, 0, 0, 0, 0);
    cycle();
    drive_a(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle();
    rst_a = 1'b1;
    cycle();
    rst_a = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      check("reinit_ready", 32'(bus_a.ready), 32'(k == 8));
    end
    drive_a(0, 1, 7, 0, 0, 0);
    cycle();
    check("reinit_rd7", 32'(bus_a.rd_data), 32'hE2);
    drive_a(0, 0, 0, 0, 0, 0);

    // Wide instance: 16 entries of 16 bits.
    rst_b = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cycle();
      check("b_ready", 32'(bus_b.ready), 32'(k == 16));
    end
    bus_b.rd_en  = 1'b1;
    bus_b.rd_idx = 4'd6;
    cycle();
    check("b_rd6", 32'(bus_b.rd_data), 32'hFFFF);
    check("b_valid", 32'(bus_b.rd_valid), 32'd1);
    bus_b.rd_idx = 4'd7;
    cycle();
    check("b_rd7", 32'(bus_b.rd_data), 32'hFFE2);
    bus_b.rd_idx = 4'd9;
    cycle();
    check("b_rd9", 32'(bus_b.rd_data), 32'h0000);
    bus_b.rd_en = 1'b0;
    cycle();
    check("b_valid_off", 32'(bus_b.rd_valid), 32'd0);

    // Randomized traffic with occasional restore and reset.
    for (int n = 0; n < 600; n++) begin
      rst_a = ($urandom_range(0, 199) == 0);
      drive_a($urandom_range(0, 39) == 0,
              1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 255)));
      cycle();
    end
    rst_a = 1'b0;
    drive_a(0, 0, 0, 0, 0, 0);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
